// File: rtl/sar_pkg.sv
// Shared types and defaults for the FRIDA SAR ADC successive-approximation controller.
package sar_pkg;

  localparam int SAR_N_BITS_DEF        = 8;
  localparam int SAR_SAMPLE_CYCLES_DEF = 2;

  // Sample counter must hold SAMPLE_CYCLES-1 for the full legal range 1..15.
  localparam int SAR_SCNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    COMP    = 3'd2,
    RESOLVE = 3'd3,
    DONE    = 3'd4
  } sar_state_e;

endpackage : sar_pkg

// File: rtl/sar_logic.sv
// SAR controller: sample switch, comparator clocking, binary search on the cap DAC, result word.
// Optional macro SAR_COMP_CHECK_EN adds comp_err, flagging unresolved comparator decisions.
module sar_logic
  import sar_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS_DEF,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              comp_p,
  input  logic              comp_n,
  output logic              comp_clk,
  output logic              samp,
  output logic [N_BITS-1:0] dac_p,
  output logic [N_BITS-1:0] dac_n,
  output logic              busy,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid
`ifdef SAR_COMP_CHECK_EN
  ,
  output logic              comp_err
`endif
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_MSB   = IDX_W'(N_BITS - 1);
  localparam logic [SAR_SCNT_W-1:0] SCNT_LAST = SAR_SCNT_W'(SAMPLE_CYCLES - 1);

  localparam logic [2:0] ST_IDLE    = 3'(IDLE);
  localparam logic [2:0] ST_SAMPLE  = 3'(SAMPLE);
  localparam logic [2:0] ST_COMP    = 3'(COMP);
  localparam logic [2:0] ST_RESOLVE = 3'(RESOLVE);
  localparam logic [2:0] ST_DONE    = 3'(DONE);

  logic [2:0]            state;
  logic [IDX_W-1:0]      bit_idx;
  logic [SAR_SCNT_W-1:0] samp_cnt;
  logic [N_BITS-1:0]     dac_reg;
  logic                  decision;

`ifdef SAR_COMP_CHECK_EN
  logic comp_bad;
  logic err_flag;

  // Equal rails mean the comparator did not resolve; treat as "below" and remember it.
  assign comp_bad = (comp_p == comp_n);
  assign decision = comp_p & ~comp_bad;
`else
  logic unused_comp_n;

  assign unused_comp_n = comp_n;
  assign decision      = comp_p;
`endif

  // Both DAC sides come from one register so they can never be skewed by a cycle.
  assign dac_p = dac_reg;
  assign dac_n = ~dac_reg;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_idx    <= IDX_MSB;
      samp_cnt   <= '0;
      dac_reg    <= '0;
      comp_clk   <= 1'b0;
      samp       <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifdef SAR_COMP_CHECK_EN
      err_flag   <= 1'b0;
      comp_err   <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SAMPLE;
            samp     <= 1'b1;
            busy     <= 1'b1;
            dac_reg  <= '0;
            samp_cnt <= '0;
            bit_idx  <= IDX_MSB;
`ifdef SAR_COMP_CHECK_EN
            err_flag <= 1'b0;
            comp_err <= 1'b0;
`endif
          end
        end

        ST_SAMPLE: begin
          if (samp_cnt == SCNT_LAST) begin
            state               <= ST_COMP;
            samp                <= 1'b0;
            comp_clk            <= 1'b1;
            dac_reg[N_BITS-1]   <= 1'b1;
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end

        ST_COMP: begin
          comp_clk <= 1'b0;
          state    <= ST_RESOLVE;
        end

        // Comparator output has had a full cycle to settle since the comp_clk rise.
        ST_RESOLVE: begin
          dac_reg[bit_idx] <= decision;
`ifdef SAR_COMP_CHECK_EN
          err_flag <= err_flag | comp_bad;
`endif
          if (bit_idx != '0) begin
            dac_reg[bit_idx - 1'b1] <= 1'b1;
            bit_idx                 <= bit_idx - 1'b1;
            comp_clk                <= 1'b1;
            state                   <= ST_COMP;
          end else begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          data_out   <= dac_reg;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          bit_idx    <= IDX_MSB;
          state      <= ST_IDLE;
`ifdef SAR_COMP_CHECK_EN
          comp_err   <= err_flag;
`endif
        end

        default: begin
          state    <= ST_IDLE;
          comp_clk <= 1'b0;
          samp     <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule : sar_logic

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic with a behavioural comparator: comp_p = (vin_code >= dac_p).
module tb_sar_logic;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       comp_p;
  logic       comp_n;
  logic       comp_clk;
  logic       samp;
  logic [7:0] dac_p;
  logic [7:0] dac_n;
  logic       busy;
  logic [7:0] data_out;
  logic       data_valid;
  logic       comp_err;

  logic [7:0] vin_code;
  bit         frc;

  int n_cmp;
  int n_err;

  // Per-conversion observations, gathered #1 after every rising edge.
  int   lat;
  bit   got;
  int   cc_cnt;
  int   samp_cnt;
  int   busy_cnt;
  int   adj_cnt;
  int   inv_cnt;
  logic prev_cc;
  logic err_at_accept;

  assign comp_p = frc ? 1'b1 : (vin_code >= dac_p);
  assign comp_n = frc ? 1'b1 : ~(vin_code >= dac_p);

  sar_logic #(
    .N_BITS        (8),
    .SAMPLE_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .comp_p     (comp_p),
    .comp_n     (comp_n),
    .comp_clk   (comp_clk),
    .samp       (samp),
    .dac_p      (dac_p),
    .dac_n      (dac_n),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid)
`ifdef SAR_COMP_CHECK_EN
    ,
    .comp_err   (comp_err)
`endif
  );

`ifndef SAR_COMP_CHECK_EN
  assign comp_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vin;
    bit         repulse;
    logic [7:0] exp_data;
    int         exp_lat;
    int         exp_cc;
    int         exp_samp;
    int         exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe();
    if (comp_clk) begin
      cc_cnt++;
      if (prev_cc) adj_cnt++;
    end
    if (samp) samp_cnt++;
    if (busy) busy_cnt++;
    if (dac_n !== ~dac_p) inv_cnt++;
    prev_cc = comp_clk;
  endtask

  // One conversion from a start pulse; returns with the bench sitting #1 after the data_valid edge.
  task automatic run_conv(input logic [7:0] v, input bit repulse, input int force_res);
    bit res_entry;
    vin_code = v;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat = 0; got = 1'b0; cc_cnt = 0; samp_cnt = 0; busy_cnt = 0;
    adj_cnt = 0; inv_cnt = 0; prev_cc = 1'b0;
    err_at_accept = comp_err;
    observe();
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      frc       = 1'b0;
      res_entry = prev_cc && !comp_clk;
      observe();
      if (data_valid) got = 1'b1;
      start = repulse && (lat == 5 || lat == 10);
      if (force_res > 0 && res_entry && cc_cnt == force_res) frc = 1'b1;
    end
    start = 1'b0;
    frc   = 1'b0;
    check("dv_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_dv(output int cycles);
    bit seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (data_valid) seen = 1'b1;
    end
    check("dv_seen_b2b", 32'(seen), 32'd1);
  endtask

  initial begin
    int t1;
    int t2;
    int dv_during_rst;

    n_cmp = 0;
    n_err = 0;
    vin_code = 8'h00;
    frc   = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{vin: 8'hA5, repulse: 1'b0, exp_data: 8'hA5, exp_lat: 19, exp_cc: 8, exp_samp: 2, exp_busy: 19};
    vecs[1] = '{vin: 8'h00, repulse: 1'b0, exp_data: 8'h00, exp_lat: 19, exp_cc: 8, exp_samp: 2, exp_busy: 19};
    vecs[2] = '{vin: 8'hFF, repulse: 1'b0, exp_data: 8'hFF, exp_lat: 19, exp_cc: 8, exp_samp: 2, exp_busy: 19};
    vecs[3] = '{vin: 8'h55, repulse: 1'b1, exp_data: 8'h55, exp_lat: 19, exp_cc: 8, exp_samp: 2, exp_busy: 19};
    vecs[4] = '{vin: 8'h7E, repulse: 1'b0, exp_data: 8'h7E, exp_lat: 19, exp_cc: 8, exp_samp: 2, exp_busy: 19};
    vecs[5] = '{vin: 8'h01, repulse: 1'b0, exp_data: 8'h01, exp_lat: 19, exp_cc: 8, exp_samp: 2, exp_busy: 19};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {comp_clk, samp, busy, data_valid, dac_p, dac_n, data_out},
          {4'b0000, 8'h00, 8'hFF, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_release", {busy, samp, comp_clk}, 3'b000);

    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].vin, vecs[i].repulse, 0);
      check($sformatf("latency[%0d]", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("data[%0d]", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("comp_clk_pulses[%0d]", i), 32'(cc_cnt), 32'(vecs[i].exp_cc));
      check($sformatf("comp_clk_adjacent[%0d]", i), 32'(adj_cnt), 32'd0);
      check($sformatf("samp_cycles[%0d]", i), 32'(samp_cnt), 32'(vecs[i].exp_samp));
      check($sformatf("busy_cycles[%0d]", i), 32'(busy_cnt), 32'(vecs[i].exp_busy));
      check($sformatf("dac_n_inverse[%0d]", i), 32'(inv_cnt), 32'd0);
      @(posedge clk); #1;
      check($sformatf("dv_one_cycle[%0d]", i), {data_valid, busy, data_out}, {2'b00, vecs[i].exp_data});
    end

    // Start held high: back-to-back conversions, IDLE re-accepts right after DONE.
    vin_code = 8'h3C;
    start    = 1'b1;
    @(posedge clk); #1;
    wait_dv(t1);
    check("b2b_lat_first", 32'(t1), 32'd19);
    check("b2b_data_first", 32'(data_out), 32'h3C);
    vin_code = 8'hC3;
    wait_dv(t2);
    start = 1'b0;
    check("b2b_spacing", 32'(t2), 32'd20);
    check("b2b_data_second", 32'(data_out), 32'hC3);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_stops", {busy, data_valid}, 2'b00);

    // Reset in the middle of a conversion aborts it with no result.
    vin_code = 8'h5A;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {comp_clk, samp, busy, data_valid, dac_p, dac_n, data_out},
          {4'b0000, 8'h00, 8'hFF, 8'h00});
    dv_during_rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (data_valid) dv_during_rst++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (data_valid) dv_during_rst++;
    end
    check("no_dv_after_abort", 32'(dv_during_rst), 32'd0);
    check("idle_after_abort", {busy, data_out}, 9'h000);

    run_conv(8'h81, 1'b0, 0);
    check("post_reset_latency", 32'(lat), 32'd19);
    check("post_reset_data", 32'(data_out), 32'h81);
    check("post_reset_pulses", 32'(cc_cnt), 32'd8);

`ifdef SAR_COMP_CHECK_EN
    // Unresolved decision on the 3rd bit (bit 5): bit cleared, error flagged with the result.
    run_conv(8'hFF, 1'b0, 3);
    check("err_data", 32'(data_out), 32'hDF);
    check("err_flag_with_dv", 32'(comp_err), 32'd1);
    @(posedge clk); #1;
    check("err_held", 32'(comp_err), 32'd1);
    run_conv(8'h10, 1'b0, 0);
    check("err_cleared_on_accept", 32'(err_at_accept), 32'd0);
    check("err_clean_data", 32'(data_out), 32'h10);
    check("err_clean_flag", 32'(comp_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sar_logic

// File: doc/sar_logic.md
Name: sar_logic

Overview:
- Successive-approximation controller for the FRIDA SAR ADC. It is the consumer of the differential comparator's decision outputs.
- Owns the input sample switch, fires the comparator clock once per bit, reads the comparator's differential decision, and drives the capacitive DAC switch states.
- Emits one N_BITS result word per conversion.

Parameters:
- N_BITS, 8: conversion resolution; also the width of the DAC and result buses.
- SAMPLE_CYCLES, 2: clk cycles the sample switch is held closed; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request; level-sampled only in IDLE.
- comp_p  in  1  comparator positive decision output.
- comp_n  in  1  comparator negative decision output.
- comp_clk  out  1  comparator clock; registered, glitch-free.
- samp  out  1  sample switch enable; high = tracking.
- dac_p  out  N_BITS  positive-side DAC switch code.
- dac_n  out  N_BITS  negative-side DAC switch code; always the bitwise inverse of dac_p.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- data_out  out  N_BITS  last completed result; holds until overwritten.
- data_valid  out  1  one-cycle pulse when data_out updates.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - comp_clk=0, samp=0, busy=0, data_valid=0.
  - dac_p=0, dac_n=all-ones, data_out=0, bit index=N_BITS-1.
- State machine, one state per cycle unless stated:
  - IDLE: if start=1 -> SAMPLE. Next cycle samp=1, busy=1, dac_p=0.
  - SAMPLE: samp=1 for exactly SAMPLE_CYCLES cycles, counted by a sample counter. On the final cycle -> COMP; in the same transition dac_p[N_BITS-1]=1 and samp=0.
  - COMP: comp_clk=1 for one cycle -> RESOLVE.
  - RESOLVE: comp_clk=0. At the end of the cycle the decision is captured as d=comp_p.
    - If d=0, the trial bit dac_p[i] is cleared.
    - If i>0: set dac_p[i-1]=1, decrement i, -> COMP.
    - If i=0: -> DONE.
  - DONE: data_out <= dac_p including the final decision, data_valid=1, busy=0, -> IDLE. i reloads to N_BITS-1.
- Latency from start sampled high to data_valid: 1 + SAMPLE_CYCLES + 2*N_BITS cycles. For the defaults that is 19 cycles.
- comp_clk is high in exactly N_BITS non-adjacent cycles per conversion.
- start while busy=1 is ignored and not queued.
- start held high continuously gives back-to-back conversions: IDLE re-accepts on the cycle after DONE.
- Reset mid-conversion aborts immediately.
  - data_out keeps no partial value: it goes to 0 by reset.
  - No data_valid pulse is produced.
- dac_n = ~dac_p combinationally from the same register, so both sides change in the same cycle.
- comp_p/comp_n are asynchronous to clk. They are sampled only in RESOLVE, a full cycle after the comp_clk rise; no other sampling is permitted.

Optional Feature:
- Macro: SAR_COMP_CHECK_EN.
- With the macro defined:
  - Extra output comp_err (1 bit, reset 0).
  - In RESOLVE, comp_p==comp_n (unresolved or metastable decision) forces d=0 and sets a sticky error flag.
  - comp_err presents the flag with data_valid in DONE and clears when the next conversion is accepted.
- Without the macro: the port is absent, d=comp_p, and comp_n is unused.

Decomposition:
- Shared package sar_pkg:
  - State enum: IDLE, SAMPLE, COMP, RESOLVE, DONE.
  - Default constants SAR_N_BITS_DEF=8 and SAR_SAMPLE_CYCLES_DEF=2.
  - Width of the sample counter, derived as 4 bits.
- No sub-module. FSM, bit index, sample counter and DAC register are tightly coupled and stay in sar_logic.

Test Plan:
All scenarios use N_BITS=8, SAMPLE_CYCLES=2. The behavioural comparator model drives comp_p = (vin_code >= dac_p) and comp_n = ~comp_p.
- vin_code=0xA5, single start pulse -> data_valid exactly 19 cycles later, data_out=0xA5, 8 comp_clk pulses, samp high for 2 cycles.
- vin_code=0x00, then 0xFF -> data_out=0x00, then 0xFF; dac_n==~dac_p on every cycle.
- start held high, codes 0x3C then 0xC3 -> two data_valid pulses 20 cycles apart with the correct values.
- start re-pulsed at cycles 5 and 10 of a 0x55 conversion -> ignored; a single result 0x55; busy never drops early.
- rst_n low at cycle 8 of a conversion -> outputs at reset values within the same cycle, no data_valid; the next conversion of 0x81 is correct.
- With SAR_COMP_CHECK_EN defined, force comp_p=comp_n=1 during the 3rd RESOLVE -> that bit=0, comp_err=1 alongside data_valid, cleared on the next start.
